// File: rtl/spi_dac_multich_ramp_if.sv
// -----------------------------------------------------------------------------
// spi_dac_multich_ramp_if
// Bundles the control inputs and the DAC-side outputs of spi_dac_multich_ramp.
//   master : the ramp generator (drives the SPI pins and status, reads controls)
//   slave  : whatever drives enable/step and observes the pins
// Signals:
//   enable      run when high; low clears the generator synchronously
//   step        DAC_BITS base increment per full channel sweep
//   cs_n        DAC chip select, active low
//   sclk        SPI clock, mode 0
//   sdo         serial data, MSB first
//   ch_idx      CH_W channel of the current/last frame
//   frame_done  one-cycle pulse as cs_n rises after the final bit
// -----------------------------------------------------------------------------
interface spi_dac_multich_ramp_if #(
  parameter int DAC_BITS = 12,
  parameter int CH_W     = 1
);
  logic                enable;
  logic [DAC_BITS-1:0] step;
  logic                cs_n;
  logic                sclk;
  logic                sdo;
  logic [CH_W-1:0]     ch_idx;
  logic                frame_done;

  modport master (
    input  enable, step,
    output cs_n, sclk, sdo, ch_idx, frame_done
  );

  modport slave (
    output enable, step,
    input  cs_n, sclk, sdo, ch_idx, frame_done
  );
endinterface

// File: rtl/spi_dac_multich_ramp.sv
// -----------------------------------------------------------------------------
// spi_dac_multich_ramp
// Multi-channel sawtooth generator for an MCP49xx-style serial DAC. Channels
// are serviced round-robin; each channel gets a fixed phase offset of
// c * 2^DAC_BITS / N_CH on top of a shared base that advances by a latched
// step once per full sweep.
//
// Ports:
//   clk     system clock, everything on posedge
//   rst_n   asynchronous active-low reset
//   bus     spi_dac_multich_ramp_if.master (enable, step in; cs_n, sclk,
//           sdo, ch_idx, frame_done out)
//   ldac_n  (only with SPI_DAC_LDAC_EN) active-low load pulse, one clk wide,
//           T_CSH-1 cycles after the last channel's frame_done
//
// Optional feature macro: SPI_DAC_LDAC_EN (adds ldac_n; needs T_CSH >= 2).
// Without it the board ties LDAC low and each frame updates its channel.
//
// Frame timing: T_CSH cycles CS high, then FRAME_BITS bits each of DIV clk
// low + DIV clk high on sclk. sdo shifts on sclk fall so it is stable at rise.
// -----------------------------------------------------------------------------
module spi_dac_multich_ramp #(
  parameter int                DAC_BITS = 12,
  parameter int                HDR_BITS = 4,
  parameter logic [HDR_BITS-1:0] HDR_BASE = 4'b0001,
  parameter int                N_CH     = 2,
  parameter int                DIV      = 1,
  parameter int                T_CSH    = 2,
  localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_dac_multich_ramp_if.master bus
`ifdef SPI_DAC_LDAC_EN
  ,
  output logic                   ldac_n
`endif
);

  localparam int FRAME_BITS = HDR_BITS + DAC_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int TMAX       = (T_CSH > DIV) ? T_CSH : DIV;
  localparam int TMR_W      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CH_OFFS    = (1 << DAC_BITS) / N_CH;

  localparam logic [TMR_W-1:0] T_CSH_LD = TMR_W'(T_CSH - 1);
  localparam logic [TMR_W-1:0] DIV_LD   = TMR_W'(DIV - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_CSH  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Per-channel header and phase offset are constants; build them as tables.
  logic [HDR_BITS-1:0] hdr_tab  [N_CH];
  logic [DAC_BITS-1:0] offs_tab [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign hdr_tab[gi]  = HDR_BASE | HDR_BITS'(gi << (HDR_BITS - CH_W));
      assign offs_tab[gi] = DAC_BITS'(gi * CH_OFFS);
    end
  endgenerate

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       ch_idx_q, ch_idx_d;
  logic [DAC_BITS-1:0]   base_q, base_d;
  logic [DAC_BITS-1:0]   step_lat_q, step_lat_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  frame_done_q, frame_done_d;
  logic [DAC_BITS-1:0]   code_w;
`ifdef SPI_DAC_LDAC_EN
  logic                  ldac_n_q, ldac_n_d;
  logic                  ldac_pend_q, ldac_pend_d;
  logic [TMR_W-1:0]      ldac_cnt_q, ldac_cnt_d;
`endif

  // Code for the channel about to be loaded; wraps mod 2^DAC_BITS.
  assign code_w = base_q + offs_tab[ch_q];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    ch_d         = ch_q;
    ch_idx_d     = ch_idx_q;
    base_d       = base_q;
    step_lat_d   = step_lat_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    frame_done_d = 1'b0;
`ifdef SPI_DAC_LDAC_EN
    ldac_n_d    = 1'b1;
    ldac_pend_d = ldac_pend_q;
    ldac_cnt_d  = ldac_cnt_q;
    if (ldac_pend_q) begin
      if (ldac_cnt_q == '0) begin
        ldac_n_d    = 1'b0;
        ldac_pend_d = 1'b0;
      end else begin
        ldac_cnt_d = ldac_cnt_q - TMR_W'(1);
      end
    end
`endif

    if (!bus.enable) begin
      // Synchronous clear: any partial frame is dropped, ramp restarts at 0.
      state_d    = ST_CSH;
      timer_d    = T_CSH_LD;
      bitcnt_d   = '0;
      shreg_d    = '0;
      ch_d       = '0;
      ch_idx_d   = '0;
      base_d     = '0;
      step_lat_d = '0;
      cs_n_d     = 1'b1;
      sclk_d     = 1'b0;
`ifdef SPI_DAC_LDAC_EN
      ldac_n_d    = 1'b1;
      ldac_pend_d = 1'b0;
      ldac_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_CSH: begin
          if (timer_q == '0) begin
            cs_n_d   = 1'b0;
            shreg_d  = {hdr_tab[ch_q], code_w};
            bitcnt_d = '0;
            ch_idx_d = ch_q;
            timer_d  = DIV_LD;
            state_d  = ST_LOW;
            // Step is captured once per sweep so all channels share a base.
            if (ch_q == '0) step_lat_d = bus.step;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end

        ST_LOW: begin
          if (timer_q == '0) begin
            sclk_d  = 1'b1;
            timer_d = DIV_LD;
            state_d = ST_HIGH;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end

        ST_HIGH: begin
          if (timer_q == '0) begin
            sclk_d = 1'b0;
            if (bitcnt_q != LAST_BIT) begin
              shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
              bitcnt_d = bitcnt_q + BC_W'(1);
              timer_d  = DIV_LD;
              state_d  = ST_LOW;
            end else begin
              cs_n_d       = 1'b1;
              frame_done_d = 1'b1;
              timer_d      = T_CSH_LD;
              state_d      = ST_CSH;
              if (ch_q == LAST_CH) begin
                ch_d   = '0;
                base_d = base_q + step_lat_q;
`ifdef SPI_DAC_LDAC_EN
                // Fires one cycle before the next frame's cs_n fall.
                ldac_pend_d = 1'b1;
                ldac_cnt_d  = TMR_W'(T_CSH - 2);
`endif
              end else begin
                ch_d = ch_q + CH_W'(1);
              end
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end

        default: begin
          state_d = ST_CSH;
          timer_d = T_CSH_LD;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CSH;
      timer_q      <= T_CSH_LD;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      ch_q         <= '0;
      ch_idx_q     <= '0;
      base_q       <= '0;
      step_lat_q   <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
      ldac_n_q     <= 1'b1;
      ldac_pend_q  <= 1'b0;
      ldac_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      ch_q         <= ch_d;
      ch_idx_q     <= ch_idx_d;
      base_q       <= base_d;
      step_lat_q   <= step_lat_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      frame_done_q <= frame_done_d;
`ifdef SPI_DAC_LDAC_EN
      ldac_n_q     <= ldac_n_d;
      ldac_pend_q  <= ldac_pend_d;
      ldac_cnt_q   <= ldac_cnt_d;
`endif
    end
  end

  assign bus.cs_n       = cs_n_q;
  assign bus.sclk       = sclk_q;
  assign bus.sdo        = shreg_q[FRAME_BITS-1];
  assign bus.ch_idx     = ch_idx_q;
  assign bus.frame_done = frame_done_q;
`ifdef SPI_DAC_LDAC_EN
  assign ldac_n         = ldac_n_q;
`endif

endmodule

// File: tb/tb_spi_dac_multich_ramp.sv
// -----------------------------------------------------------------------------
// tb_spi_dac_multich_ramp
// Two instances: A uses the default parameters (2 channels, DIV=1, T_CSH=2),
// B uses N_CH=4, DIV=3. Frames are reassembled from sdo on sclk rises and
// compared against hand-computed tables; timing and abort/reset behaviour is
// covered by short directed sequences.
// -----------------------------------------------------------------------------
module tb_spi_dac_multich_ramp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_dac_multich_ramp_if #(.DAC_BITS(12), .CH_W(1)) bus_a ();
  spi_dac_multich_ramp_if #(.DAC_BITS(12), .CH_W(2)) bus_b ();
`ifdef SPI_DAC_LDAC_EN
  logic ldac_a;
  logic ldac_b;
`endif

  spi_dac_multich_ramp u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
`ifdef SPI_DAC_LDAC_EN
    ,
    .ldac_n(ldac_a)
`endif
  );

  spi_dac_multich_ramp #(.N_CH(4), .DIV(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
`ifdef SPI_DAC_LDAC_EN
    ,
    .ldac_n(ldac_b)
`endif
  );

  // ---------------- monitors (sample on negedge) ----------------
  logic        sclk_pa = 1'b0, sdo_pa = 1'b0;
  logic [15:0] sh_a = '0;
  int rises_a = 0, sdo_viol_a = 0;
  int lowcnt_a = 0, highcnt_a = 0, last_low_a = 0, last_high_a = 0;
  int fdcnt_a = 0, last_fdw_a = 0, ldac_lows_a = 0;

  always @(negedge clk) begin
    sclk_pa <= bus_a.sclk;
    sdo_pa  <= bus_a.sdo;
    if (bus_a.cs_n) begin
      rises_a <= 0;
    end else if (bus_a.sclk && !sclk_pa) begin
      sh_a    <= {sh_a[14:0], bus_a.sdo};
      rises_a <= rises_a + 1;
      if (bus_a.sdo !== sdo_pa) sdo_viol_a <= sdo_viol_a + 1;
    end
    if (!bus_a.cs_n) lowcnt_a <= lowcnt_a + 1;
    else if (lowcnt_a != 0) begin last_low_a <= lowcnt_a; lowcnt_a <= 0; end
    if (bus_a.cs_n) highcnt_a <= highcnt_a + 1;
    else if (highcnt_a != 0) begin last_high_a <= highcnt_a; highcnt_a <= 0; end
    if (bus_a.frame_done) fdcnt_a <= fdcnt_a + 1;
    else if (fdcnt_a != 0) begin last_fdw_a <= fdcnt_a; fdcnt_a <= 0; end
`ifdef SPI_DAC_LDAC_EN
    if (!ldac_a) ldac_lows_a <= ldac_lows_a + 1;
`endif
  end

  logic        sclk_pb = 1'b0;
  logic [15:0] sh_b = '0;
  int since_b = 0, last_per_b = 0, ldac_lows_b = 0;

  always @(negedge clk) begin
    sclk_pb <= bus_b.sclk;
    if (!bus_b.cs_n && bus_b.sclk && !sclk_pb) begin
      sh_b       <= {sh_b[14:0], bus_b.sdo};
      last_per_b <= since_b;
      since_b    <= 1;
    end else begin
      since_b <= since_b + 1;
    end
`ifdef SPI_DAC_LDAC_EN
    if (!ldac_b) ldac_lows_b <= ldac_lows_b + 1;
`endif
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_frame_a(input int budget, output logic [15:0] w,
                              output logic [1:0] ch, output logic ok);
    ok = 1'b0; w = '0; ch = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_a.frame_done) begin
        w = sh_a; ch = 2'(bus_a.ch_idx); ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frame_b(input int budget, output logic [15:0] w,
                              output logic [1:0] ch, output logic ok);
    ok = 1'b0; w = '0; ch = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_b.frame_done) begin
        w = sh_b; ch = bus_b.ch_idx; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cycles_to_cs_fall_a(output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (!bus_a.cs_n) break;
    end
  endtask

  function automatic logic [4:0] pins_a();
    return {bus_a.cs_n, bus_a.sclk, bus_a.sdo, bus_a.frame_done, 1'(bus_a.ch_idx)};
  endfunction

  typedef struct {
    logic [11:0] step;
    logic [15:0] word;
    logic [1:0]  ch;
  } vec_t;

  vec_t t1 [4];
  vec_t t3 [6];
  vec_t t6 [5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [1:0]  ch;
    logic        ok;
    int          n;
    int          last_rises;

    t1[0] = '{12'h010, 16'h1000, 2'd0};
    t1[1] = '{12'h010, 16'h9800, 2'd1};
    t1[2] = '{12'h010, 16'h1010, 2'd0};
    t1[3] = '{12'h010, 16'h9810, 2'd1};

    t3[0] = '{12'hFF0, 16'h1000, 2'd0};
    t3[1] = '{12'h010, 16'h9800, 2'd1};
    t3[2] = '{12'h010, 16'h1FF0, 2'd0};
    t3[3] = '{12'h010, 16'h97F0, 2'd1};
    t3[4] = '{12'h010, 16'h1000, 2'd0};
    t3[5] = '{12'h010, 16'h9800, 2'd1};

    t6[0] = '{12'h100, 16'h1000, 2'd0};
    t6[1] = '{12'h100, 16'h5400, 2'd1};
    t6[2] = '{12'h100, 16'h9800, 2'd2};
    t6[3] = '{12'h100, 16'hDC00, 2'd3};
    t6[4] = '{12'h100, 16'h1100, 2'd0};

    rst_n = 1'b0;
    bus_a.enable = 1'b0; bus_a.step = '0;
    bus_b.enable = 1'b0; bus_b.step = '0;
    repeat (3) @(negedge clk);
    check("reset_pins", 32'(pins_a()), 32'b10000);
    $display("reset: pins=%b", pins_a());

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_disabled", 32'(pins_a()), 32'b10000);

    // Test 1: default ramp.
    bus_a.step = 12'h010;
    bus_a.enable = 1'b1;
    cycles_to_cs_fall_a(n);
    check("enable_latency", 32'(n), 32'd2);
    last_rises = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.step = t1[i].step;
      wait_frame_a(200, w, ch, ok);
      last_rises = rises_a;
      $display("t1 frame %0d: word=%h ch=%0d", i, w, ch);
      check($sformatf("t1_done_%0d", i), 32'(ok), 32'd1);
      check($sformatf("t1_word_%0d", i), 32'(w), 32'(t1[i].word));
      check($sformatf("t1_ch_%0d", i), 32'(ch), 32'(t1[i].ch));
    end

    // Test 2: timing captured during the frames above.
    repeat (2) @(negedge clk);
    check("cs_low_cycles", 32'(last_low_a), 32'd32);
    check("cs_high_cycles", 32'(last_high_a), 32'd2);
    check("sclk_rises", 32'(last_rises), 32'd16);
    check("frame_done_width", 32'(last_fdw_a), 32'd1);
    check("sdo_stable_at_rise", 32'(sdo_viol_a), 32'd0);
`ifdef SPI_DAC_LDAC_EN
    check("ldac_pulses_a", 32'(ldac_lows_a), 32'd2);
`endif

    // Test 4: abort at bit 7 of a CH1 frame.
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!bus_a.cs_n && bus_a.ch_idx == 1'b1 && rises_a == 7) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_point_found", 32'(ok), 32'd1);
    bus_a.enable = 1'b0;
    @(negedge clk);
    check("abort_pins", 32'(pins_a()), 32'b10000);
    $display("abort: pins=%b", pins_a());

    // Re-enable with a large step, then Test 3: wrap of the base.
    bus_a.step = t3[0].step;
    repeat (3) @(negedge clk);
    bus_a.enable = 1'b1;
    cycles_to_cs_fall_a(n);
    check("reenable_latency", 32'(n), 32'd2);
    for (int i = 0; i < 6; i++) begin
      bus_a.step = t3[i].step;
      wait_frame_a(200, w, ch, ok);
      $display("t3 frame %0d: word=%h ch=%0d", i, w, ch);
      check($sformatf("t3_done_%0d", i), 32'(ok), 32'd1);
      check($sformatf("t3_word_%0d", i), 32'(w), 32'(t3[i].word));
      check($sformatf("t3_ch_%0d", i), 32'(ch), 32'(t3[i].ch));
    end

    // Test 5: asynchronous reset between edges in the middle of a frame.
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!bus_a.cs_n && bus_a.sclk && bus_a.ch_idx == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("midframe_found", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_pins", 32'(pins_a()), 32'b10000);
    $display("async reset: pins=%b", pins_a());
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_a(200, w, ch, ok);
    $display("post reset frame: word=%h ch=%0d", w, ch);
    check("post_reset_word", 32'(w), 32'h1000);
    check("post_reset_ch", 32'(ch), 32'd0);
    bus_a.enable = 1'b0;

    // Test 6: four channels, DIV=3.
    bus_b.step = t6[0].step;
    @(negedge clk);
    bus_b.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_b.step = t6[i].step;
      wait_frame_b(400, w, ch, ok);
      $display("t6 frame %0d: word=%h ch=%0d", i, w, ch);
      check($sformatf("t6_done_%0d", i), 32'(ok), 32'd1);
      check($sformatf("t6_word_%0d", i), 32'(w), 32'(t6[i].word));
      check($sformatf("t6_ch_%0d", i), 32'(ch), 32'(t6[i].ch));
    end
    check("sclk_period_div3", 32'(last_per_b), 32'd6);
`ifdef SPI_DAC_LDAC_EN
    check("ldac_pulses_b", 32'(ldac_lows_b), 32'd1);
`endif
    bus_b.enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
